// File: rtl/axi_mem_resp_pkg.sv
// Shared types and constants for the AXI4 memory responder.
// The optional bounds check is enabled with the AXI_MEM_RESP_BOUNDS_CHK_EN macro.
package axi_mem_resp_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_resp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port,
// read-before-write on a same-address collision.
module axi_mem_resp_ram
    import axi_mem_resp_pkg::*;
#(
    parameter int DATA_W      = 512,
    parameter int DEPTH_RADIX = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [DEPTH_RADIX-1:0] waddr_i,
    input  logic [DATA_W/8-1:0]    wbe_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic                   re_i,
    input  logic [DEPTH_RADIX-1:0] raddr_i,
    output logic [DATA_W-1:0]      rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_RADIX];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // read register is reset, which keeps rdata at zero while in reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // NOTE: non-blocking updates mean a same-edge read samples the word before the write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by on-chip RAM; one outstanding burst per direction.
// Define AXI_MEM_RESP_BOUNDS_CHK_EN to flag bursts that run past the RAM with SLVERR.
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 512,
    parameter int ID_W        = 9,
    parameter int USER_W      = 1,
    parameter int DEPTH_RADIX = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     axi_awid_i,
    input  logic [ADDR_W-1:0]   axi_awaddr_i,
    input  logic [7:0]          axi_awlen_i,
    input  logic [2:0]          axi_awsize_i,
    input  logic [1:0]          axi_awburst_i,
    input  logic                axi_awlock_i,
    input  logic [3:0]          axi_awcache_i,
    input  logic [2:0]          axi_awprot_i,
    input  logic [USER_W-1:0]   axi_awuser_i,
    input  logic                axi_awvalid_i,
    output logic                axi_awready_o,
    input  logic [DATA_W-1:0]   axi_wdata_i,
    input  logic [DATA_W/8-1:0] axi_wstrb_i,
    input  logic                axi_wlast_i,
    input  logic                axi_wvalid_i,
    output logic                axi_wready_o,
    output logic [ID_W-1:0]     axi_bid_o,
    output logic [1:0]          axi_bresp_o,
    output logic [USER_W-1:0]   axi_buser_o,
    output logic                axi_bvalid_o,
    input  logic                axi_bready_i,
    input  logic [ID_W-1:0]     axi_arid_i,
    input  logic [ADDR_W-1:0]   axi_araddr_i,
    input  logic [7:0]          axi_arlen_i,
    input  logic [2:0]          axi_arsize_i,
    input  logic [1:0]          axi_arburst_i,
    input  logic                axi_arlock_i,
    input  logic [3:0]          axi_arcache_i,
    input  logic [2:0]          axi_arprot_i,
    input  logic [USER_W-1:0]   axi_aruser_i,
    input  logic                axi_arvalid_i,
    output logic                axi_arready_o,
    output logic [ID_W-1:0]     axi_rid_o,
    output logic [DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    output logic                axi_rlast_o,
    output logic [USER_W-1:0]   axi_ruser_o,
    output logic                axi_rvalid_o,
    input  logic                axi_rready_i
);

    localparam int LSB   = $clog2(DATA_W/8);
    localparam int IDX_W = ADDR_W - LSB;
    localparam int DEPTH = 2**DEPTH_RADIX;

    w_state_t               w_state_q;
    logic                   awready_q, wready_q, bvalid_q, w_oob_q;
    logic [ID_W-1:0]        bid_q;
    logic [USER_W-1:0]      buser_q;
    logic [1:0]             bresp_q;
    logic [DEPTH_RADIX-1:0] w_idx_q;
    logic [7:0]             w_cnt_q;

    r_state_t               r_state_q;
    logic                   arready_q, rvalid_q, rlast_q, r_oob_q;
    logic [ID_W-1:0]        rid_q;
    logic [USER_W-1:0]      ruser_q;
    logic [1:0]             rresp_q;
    logic [DEPTH_RADIX-1:0] r_idx_q;
    logic [7:0]             r_cnt_q;

    logic                   aw_oob, ar_oob;
    logic                   ram_we_d, ram_re_d;
    logic [DATA_W-1:0]      ram_rdata;

`ifdef AXI_MEM_RESP_BOUNDS_CHK_EN
    // Last beat index = start index + len, compared against the RAM depth.
    logic [IDX_W:0] aw_end, ar_end;
    assign aw_end = {1'b0, axi_awaddr_i[ADDR_W-1:LSB]} + (IDX_W+1)'(axi_awlen_i);
    assign ar_end = {1'b0, axi_araddr_i[ADDR_W-1:LSB]} + (IDX_W+1)'(axi_arlen_i);
    assign aw_oob = aw_end >= (IDX_W+1)'(DEPTH);
    assign ar_oob = ar_end >= (IDX_W+1)'(DEPTH);
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            buser_q   <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_oob_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awready_q && axi_awvalid_i) begin
                        bid_q     <= axi_awid_i;
                        buser_q   <= axi_awuser_i;
                        w_idx_q   <= axi_awaddr_i[LSB +: DEPTH_RADIX];
                        w_cnt_q   <= axi_awlen_i;
                        w_oob_q   <= aw_oob;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid_i) begin
                        w_idx_q <= w_idx_q + 1'b1;
                        if (w_cnt_q == 8'd0) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_oob_q ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_cnt_q <= w_cnt_q - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // A beat completes on rready; the next word is fetched in the same edge so
    // a held rready streams one beat per cycle and a stall freezes the RAM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ruser_q   <= '0;
            rresp_q   <= RESP_OKAY;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_oob_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && axi_arvalid_i) begin
                        rid_q     <= axi_arid_i;
                        ruser_q   <= axi_aruser_i;
                        r_idx_q   <= axi_araddr_i[LSB +: DEPTH_RADIX];
                        r_cnt_q   <= axi_arlen_i;
                        r_oob_q   <= ar_oob;
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_idx_q   <= r_idx_q + 1'b1;
                    rvalid_q  <= 1'b1;
                    rlast_q   <= (r_cnt_q == 8'd0);
                    rresp_q   <= r_oob_q ? RESP_SLVERR : RESP_OKAY;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (axi_rready_i) begin
                        if (r_cnt_q == 8'd0) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q - 8'd1;
                            r_idx_q <= r_idx_q + 1'b1;
                            rlast_q <= (r_cnt_q == 8'd1);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign ram_we_d = (w_state_q == W_DATA) && axi_wvalid_i && !w_oob_q;
    assign ram_re_d = (r_state_q == R_FETCH) ||
                      ((r_state_q == R_DATA) && axi_rready_i && (r_cnt_q != 8'd0));

    axi_mem_resp_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_RADIX (DEPTH_RADIX)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we_d),
        .waddr_i (w_idx_q),
        .wbe_i   (axi_wstrb_i),
        .wdata_i (axi_wdata_i),
        .re_i    (ram_re_d),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bid_o     = bid_q;
    assign axi_buser_o   = buser_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rlast_o   = rlast_q;
    assign axi_rid_o     = rid_q;
    assign axi_ruser_o   = ruser_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rdata_o   = r_oob_q ? '0 : ram_rdata;

    logic unused_ok;
    assign unused_ok = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i, axi_awprot_i,
                         axi_arsize_i, axi_arburst_i, axi_arlock_i, axi_arcache_i, axi_arprot_i,
                         axi_wlast_i, axi_awaddr_i, axi_araddr_i};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (DATA_W=512, DEPTH_RADIX=4).
// Expectations follow AXI_MEM_RESP_BOUNDS_CHK_EN when it is defined.
module tb_axi_mem_responder;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 512;
    localparam int ID_W        = 9;
    localparam int USER_W      = 1;
    localparam int DEPTH_RADIX = 4;
    localparam int STRB_W      = DATA_W/8;
    localparam int BOUND       = 50;

    logic clk, rst;
    logic [ID_W-1:0]   axi_awid_i, axi_arid_i, axi_bid_o, axi_rid_o;
    logic [ADDR_W-1:0] axi_awaddr_i, axi_araddr_i;
    logic [7:0]        axi_awlen_i, axi_arlen_i;
    logic [2:0]        axi_awsize_i, axi_arsize_i, axi_awprot_i, axi_arprot_i;
    logic [1:0]        axi_awburst_i, axi_arburst_i, axi_bresp_o, axi_rresp_o;
    logic              axi_awlock_i, axi_arlock_i;
    logic [3:0]        axi_awcache_i, axi_arcache_i;
    logic [USER_W-1:0] axi_awuser_i, axi_aruser_i, axi_buser_o, axi_ruser_o;
    logic              axi_awvalid_i, axi_awready_o, axi_arvalid_i, axi_arready_o;
    logic [DATA_W-1:0] axi_wdata_i, axi_rdata_o;
    logic [STRB_W-1:0] axi_wstrb_i;
    logic              axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic              axi_bvalid_o, axi_bready_i;
    logic              axi_rlast_o, axi_rvalid_o, axi_rready_i;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] wdata_tab [16];
    logic [STRB_W-1:0] wstrb_tab [16];
    logic [DATA_W-1:0] got_data  [16];
    logic              got_last  [16];
    logic [1:0]        got_resp  [16];
    int                got_n;

    axi_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W), .DEPTH_RADIX(DEPTH_RADIX)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i), .axi_awlock_i(axi_awlock_i),
        .axi_awcache_i(axi_awcache_i), .axi_awprot_i(axi_awprot_i), .axi_awuser_i(axi_awuser_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_buser_o(axi_buser_o),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i), .axi_arlock_i(axi_arlock_i),
        .axi_arcache_i(axi_arcache_i), .axi_arprot_i(axi_arprot_i), .axi_aruser_i(axi_aruser_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_ruser_o(axi_ruser_o), .axi_rvalid_o(axi_rvalid_o),
        .axi_rready_i(axi_rready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rep(input logic [7:0] b);
        return {STRB_W{b}};
    endfunction

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [ID_W-1:0] id, input int bhold, output logic [1:0] resp);
        int n;
        axi_awaddr_i  = addr;
        axi_awlen_i   = len;
        axi_awid_i    = id;
        axi_awvalid_i = 1'b1;
        n = 0;
        while (!axi_awready_o && n < BOUND) begin tick(); n++; end
        tick();
        axi_awvalid_i = 1'b0;
        checks++;
        if (n >= BOUND || axi_wready_o !== 1'b1) begin
            errors++;
            $display("FAIL aw_to_wready: wready=%b wait=%0d required wready=1", axi_wready_o, n);
        end
        for (int b = 0; b <= int'(len); b++) begin
            axi_wdata_i  = wdata_tab[b];
            axi_wstrb_i  = wstrb_tab[b];
            axi_wlast_i  = (b == int'(len));
            axi_wvalid_i = 1'b1;
            n = 0;
            while (!axi_wready_o && n < BOUND) begin tick(); n++; end
            tick();
        end
        axi_wvalid_i = 1'b0;
        axi_wlast_i  = 1'b0;
        checks++;
        if (axi_bvalid_o !== 1'b1 || axi_bid_o !== id) begin
            errors++;
            $display("FAIL bvalid_after_last: bvalid=%b bid=%0d required 1 / %0d", axi_bvalid_o, axi_bid_o, id);
        end
        for (int h = 0; h < bhold; h++) begin
            checks++;
            if (axi_bvalid_o !== 1'b1 || axi_awready_o !== 1'b0) begin
                errors++;
                $display("FAIL b_hold[%0d]: bvalid=%b awready=%b required 1 / 0", h, axi_bvalid_o, axi_awready_o);
            end
            tick();
        end
        resp = axi_bresp_o;
        axi_bready_i = 1'b1;
        tick();
        axi_bready_i = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [ID_W-1:0] id, input bit toggle);
        int n;
        int cyc;
        bit rr;
        logic [DATA_W-1:0] hold_d;
        logic hold_l;
        axi_araddr_i  = addr;
        axi_arlen_i   = len;
        axi_arid_i    = id;
        axi_arvalid_i = 1'b1;
        n = 0;
        while (!axi_arready_o && n < BOUND) begin tick(); n++; end
        tick();
        axi_arvalid_i = 1'b0;
        checks++;
        if (axi_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL r_fetch_cycle: rvalid=%b required 0", axi_rvalid_o);
        end
        tick();
        checks++;
        if (n >= BOUND || axi_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_to_rvalid: rvalid=%b wait=%0d required rvalid=1", axi_rvalid_o, n);
        end
        got_n = 0;
        cyc = 0;
        rr = 1'b1;
        while (got_n <= int'(len) && cyc < 4 * BOUND) begin
            axi_rready_i = toggle ? rr : 1'b1;
            if (axi_rvalid_o && axi_rready_i) begin
                got_data[got_n] = axi_rdata_o;
                got_last[got_n] = axi_rlast_o;
                got_resp[got_n] = axi_rresp_o;
                checks++;
                if (axi_rid_o !== id) begin
                    errors++;
                    $display("FAIL rid[%0d]: got %0d required %0d", got_n, axi_rid_o, id);
                end
                got_n++;
                tick();
            end else if (axi_rvalid_o) begin
                hold_d = axi_rdata_o;
                hold_l = axi_rlast_o;
                tick();
                checks++;
                if (axi_rdata_o !== hold_d || axi_rlast_o !== hold_l || axi_rvalid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL r_stall_stable: rvalid=%b rlast=%b rdata=%h required held rlast=%b rdata=%h",
                             axi_rvalid_o, axi_rlast_o, axi_rdata_o, hold_l, hold_d);
                end
            end else begin
                tick();
            end
            rr = !rr;
            cyc++;
        end
        axi_rready_i = 1'b0;
        checks++;
        if (got_n != int'(len) + 1 || axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1) begin
            errors++;
            $display("FAIL r_burst_end: beats=%0d rvalid=%b arready=%b required %0d / 0 / 1",
                     got_n, axi_rvalid_o, axi_arready_o, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o, axi_rlast_o} !== 6'b0 ||
            axi_rdata_o !== '0 || axi_rid_o !== '0 || axi_bid_o !== '0 || axi_bresp_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b last=%b rdata=%h required all zero",
                     axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o, axi_rlast_o, axi_rdata_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (axi_awready_o !== 1'b0 || axi_arready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: awready=%b arready=%b required 0 / 0", axi_awready_o, axi_arready_o);
        end
        tick();
        checks++;
        if (axi_awready_o !== 1'b1 || axi_arready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: awready=%b arready=%b required 1 / 1", axi_awready_o, axi_arready_o);
        end
    endtask

    task automatic test_write_read();
        logic [1:0] resp;
        for (int b = 0; b < 4; b++) begin
            wdata_tab[b] = rep(8'((b + 1) * 17));
            wstrb_tab[b] = '1;
        end
        write_burst(32'h40, 8'd3, 9'd5, 0, resp);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL wr_bresp: got %b required 00", resp);
        end
        read_burst(32'h40, 8'd3, 9'd7, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (got_data[b] !== rep(8'((b + 1) * 17)) || got_last[b] !== (b == 3) || got_resp[b] !== 2'b00) begin
                errors++;
                $display("FAIL rd_beat[%0d]: data=%h last=%b resp=%b required byte %h last=%b resp=00",
                         b, got_data[b], got_last[b], got_resp[b], 8'((b + 1) * 17), (b == 3));
            end
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp;
        wdata_tab[0] = rep(8'hFF);
        wstrb_tab[0] = '1;
        write_burst(32'h0, 8'd0, 9'd1, 0, resp);
        wdata_tab[0] = '0;
        wstrb_tab[0] = 64'h1;
        write_burst(32'h0, 8'd0, 9'd2, 0, resp);
        read_burst(32'h0, 8'd0, 9'd3, 1'b0);
        checks++;
        if (got_data[0] !== {{(STRB_W-1){8'hFF}}, 8'h00} || got_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL partial_strobe: data=%h last=%b required byte0=00 others FF last=1", got_data[0], got_last[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        read_burst(32'h40, 8'd3, 9'd9, 1'b1);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (got_data[b] !== rep(8'((b + 1) * 17)) || got_last[b] !== (b == 3)) begin
                errors++;
                $display("FAIL stall_beat[%0d]: data=%h last=%b required byte %h last=%b",
                         b, got_data[b], got_last[b], 8'((b + 1) * 17), (b == 3));
            end
        end
        wdata_tab[0] = rep(8'h11);
        wstrb_tab[0] = '1;
        write_burst(32'h40, 8'd0, 9'd4, 5, resp);
    endtask

    task automatic test_concurrency();
        logic [1:0] resp;
        for (int b = 0; b < 8; b++) begin
            wdata_tab[b] = rep(8'(8'hA0 + b));
            wstrb_tab[b] = '1;
        end
        write_burst(32'h0, 8'd7, 9'd6, 0, resp);
        for (int b = 0; b < 8; b++) wdata_tab[b] = rep(8'(8'hB0 + b));
        fork
            write_burst(32'h200, 8'd7, 9'd10, 0, resp);
            read_burst(32'h0, 8'd7, 9'd11, 1'b0);
        join
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (got_data[b] !== rep(8'(8'hA0 + b)) || got_last[b] !== (b == 7)) begin
                errors++;
                $display("FAIL conc_read[%0d]: data=%h last=%b required byte %h", b, got_data[b], got_last[b], 8'(8'hA0 + b));
            end
        end
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL conc_bresp: got %b required 00", resp);
        end
        read_burst(32'h200, 8'd7, 9'd12, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (got_data[b] !== rep(8'(8'hB0 + b))) begin
                errors++;
                $display("FAIL conc_write[%0d]: data=%h required byte %h", b, got_data[b], 8'(8'hB0 + b));
            end
        end
    endtask

    task automatic test_collision();
        axi_awaddr_i  = 32'h80;
        axi_awlen_i   = 8'd0;
        axi_araddr_i  = 32'h80;
        axi_arlen_i   = 8'd0;
        axi_wdata_i   = rep(8'h5A);
        axi_wstrb_i   = '1;
        axi_wlast_i   = 1'b1;
        axi_wvalid_i  = 1'b1;
        axi_awvalid_i = 1'b1;
        axi_arvalid_i = 1'b1;
        tick();
        axi_awvalid_i = 1'b0;
        axi_arvalid_i = 1'b0;
        tick();
        axi_wvalid_i = 1'b0;
        axi_wlast_i  = 1'b0;
        checks++;
        if (axi_rvalid_o !== 1'b1 || axi_bvalid_o !== 1'b1 || axi_rdata_o !== rep(8'hA2)) begin
            errors++;
            $display("FAIL collision_old: rvalid=%b bvalid=%b rdata=%h required 1 / 1 / byte A2",
                     axi_rvalid_o, axi_bvalid_o, axi_rdata_o);
        end
        axi_rready_i = 1'b1;
        axi_bready_i = 1'b1;
        tick();
        axi_rready_i = 1'b0;
        axi_bready_i = 1'b0;
        read_burst(32'h80, 8'd0, 9'd13, 1'b0);
        checks++;
        if (got_data[0] !== rep(8'h5A)) begin
            errors++;
            $display("FAIL collision_new: data=%h required byte 5A", got_data[0]);
        end
    endtask

    task automatic test_bounds();
        logic [1:0] resp;
        logic [1:0] exp_resp;
        logic [DATA_W-1:0] exp15, exp0;
`ifdef AXI_MEM_RESP_BOUNDS_CHK_EN
        exp_resp = 2'b10;
        exp15    = rep(8'hB7);
        exp0     = rep(8'hA0);
`else
        exp_resp = 2'b00;
        exp15    = rep(8'hC1);
        exp0     = rep(8'hC2);
`endif
        wdata_tab[0] = rep(8'hC1);
        wdata_tab[1] = rep(8'hC2);
        wstrb_tab[0] = '1;
        wstrb_tab[1] = '1;
        write_burst(32'h3C0, 8'd1, 9'd14, 0, resp);
        checks++;
        if (resp !== exp_resp) begin
            errors++;
            $display("FAIL bounds_bresp: got %b required %b", resp, exp_resp);
        end
        read_burst(32'h3C0, 8'd1, 9'd15, 1'b0);
        checks++;
        if (got_resp[0] !== exp_resp || got_resp[1] !== exp_resp) begin
            errors++;
            $display("FAIL bounds_rresp: got %b %b required %b", got_resp[0], got_resp[1], exp_resp);
        end
`ifndef AXI_MEM_RESP_BOUNDS_CHK_EN
        checks++;
        if (got_data[0] !== exp15 || got_data[1] !== exp0) begin
            errors++;
            $display("FAIL bounds_wrap_read: beat0=%h beat1=%h", got_data[0], got_data[1]);
        end
`else
        checks++;
        if (got_data[0] !== '0 || got_data[1] !== '0) begin
            errors++;
            $display("FAIL bounds_rdata_zero: beat0=%h beat1=%h required zero", got_data[0], got_data[1]);
        end
`endif
        read_burst(32'h3C0, 8'd0, 9'd16, 1'b0);
        checks++;
        if (got_data[0] !== exp15) begin
            errors++;
            $display("FAIL bounds_word15: data=%h required %h", got_data[0], exp15);
        end
        read_burst(32'h0, 8'd0, 9'd17, 1'b0);
        checks++;
        if (got_data[0] !== exp0) begin
            errors++;
            $display("FAIL bounds_word0: data=%h required %h", got_data[0], exp0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        axi_awaddr_i  = 32'h100;
        axi_awlen_i   = 8'd3;
        axi_awid_i    = 9'd20;
        axi_awvalid_i = 1'b1;
        tick();
        axi_awvalid_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            axi_wdata_i  = rep(8'(8'hD1 + b));
            axi_wstrb_i  = '1;
            axi_wvalid_i = 1'b1;
            n = 0;
            while (!axi_wready_o && n < BOUND) begin tick(); n++; end
            tick();
        end
        axi_wvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (axi_bvalid_o !== 1'b0 || axi_wready_o !== 1'b0 || axi_awready_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset: bvalid=%b wready=%b awready=%b required 0/0/0",
                     axi_bvalid_o, axi_wready_o, axi_awready_o);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (axi_awready_o !== 1'b1 || axi_bvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: awready=%b bvalid=%b required 1 / 0", axi_awready_o, axi_bvalid_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (axi_bvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_b[%0d]: bvalid=%b required 0", c, axi_bvalid_o);
            end
        end
        read_burst(32'h100, 8'd3, 9'd21, 1'b0);
        checks++;
        if (got_data[0] !== rep(8'hD1) || got_data[1] !== rep(8'hD2) ||
            got_data[2] !== rep(8'hA6) || got_data[3] !== rep(8'hA7)) begin
            errors++;
            $display("FAIL abort_partial: b0=%h b1=%h b2=%h b3=%h",
                     got_data[0][7:0], got_data[1][7:0], got_data[2][7:0], got_data[3][7:0]);
        end
    endtask

    initial begin
        axi_awid_i = '0; axi_awaddr_i = '0; axi_awlen_i = '0; axi_awsize_i = 3'd6; axi_awburst_i = 2'b01;
        axi_awlock_i = 1'b0; axi_awcache_i = '0; axi_awprot_i = '0; axi_awuser_i = '0; axi_awvalid_i = 1'b0;
        axi_arid_i = '0; axi_araddr_i = '0; axi_arlen_i = '0; axi_arsize_i = 3'd6; axi_arburst_i = 2'b01;
        axi_arlock_i = 1'b0; axi_arcache_i = '0; axi_arprot_i = '0; axi_aruser_i = '0; axi_arvalid_i = 1'b0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
        axi_bready_i = 1'b0; axi_rready_i = 1'b0;
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_backpressure();
        test_concurrency();
        test_collision();
        test_bounds();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
